// File: rtl/qspi_ctrl_rx_if.sv
// Host-side QSPI bus plus the control outputs of the qspi_ctrl_rx receiver.
interface qspi_ctrl_rx_if;
    logic       cs_n;
    logic       sclk;
    logic [3:0] io;
    logic [7:0] control;
    logic       clk_control;
    logic       frame_err;
    logic       busy;

    modport master (
        output cs_n, sclk, io,
        input  control, clk_control, frame_err, busy
    );

    modport slave (
        input  cs_n, sclk, io,
        output control, clk_control, frame_err, busy
    );
endinterface

// File: rtl/qspi_ctrl_rx.sv
// QSPI write-control receiver: oversamples the host bus and commits 2-byte control frames.
// Optional trailing checksum byte enabled by defining QSPI_CTRL_CKSUM_EN.
module qspi_ctrl_rx (
    input  logic           clk,
    input  logic           rst,
    qspi_ctrl_rx_if.slave  bus
);
    localparam logic [7:0] OPC_WRITE = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_OPC      = 3'd1,
        ST_DATA     = 3'd2,
`ifdef QSPI_CTRL_CKSUM_EN
        ST_CKS      = 3'd3,
`endif
        ST_WAIT_END = 3'd4,
        ST_ERR      = 3'd5
    } state_t;

    logic [1:0] cs_sync_q;
    logic [1:0] sclk_sync_q;
    logic [3:0] io_sync0_q;
    logic [3:0] io_sync1_q;
    logic       cs_prev_q;
    logic       sclk_prev_q;
    logic [1:0] fill_q;
    logic       arm_q;

    state_t     state_q;
    logic       nib_q;
    logic [3:0] hi_q;
    logic [7:0] payload_q;
    logic [7:0] control_q;
    logic       clk_control_q;
    logic       frame_err_q;

    logic       sclk_rise;
    logic       cs_rise;
    logic       cs_fall;
    logic [7:0] byte_s;

    // arm_q only sets once the synchronizer holds real pin data showing cs_n high,
    // so a cs_n already low when reset releases never looks like a frame start.
    assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    assign cs_rise   = cs_sync_q[1] & ~cs_prev_q;
    assign cs_fall   = ~cs_sync_q[1] & cs_prev_q & arm_q;
    assign byte_s    = {hi_q, io_sync1_q};

    assign bus.control     = control_q;
    assign bus.clk_control = clk_control_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.busy        = ~cs_sync_q[1];

    // Two-flop synchronizers, edge-detect history and post-reset arming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_q   <= 2'b11;
            sclk_sync_q <= 2'b11;
            io_sync0_q  <= 4'h0;
            io_sync1_q  <= 4'h0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b1;
            fill_q      <= 2'd0;
            arm_q       <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], bus.cs_n};
            sclk_sync_q <= {sclk_sync_q[0], bus.sclk};
            io_sync0_q  <= bus.io;
            io_sync1_q  <= io_sync0_q;
            cs_prev_q   <= cs_sync_q[1];
            sclk_prev_q <= sclk_sync_q[1];
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end
            if ((fill_q == 2'd2) && cs_sync_q[1]) begin
                arm_q <= 1'b1;
            end
        end
    end

    // Frame FSM; cs_n rise outranks a coincident sclk edge in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            nib_q         <= 1'b0;
            hi_q          <= 4'h0;
            payload_q     <= 8'h00;
            control_q     <= 8'h00;
            clk_control_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            clk_control_q <= 1'b0;
            frame_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    nib_q <= 1'b0;
                    if (cs_fall) begin
                        state_q <= ST_OPC;
                    end
                end
                ST_OPC: begin
                    if (cs_rise) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (sclk_rise) begin
                        if (!nib_q) begin
                            hi_q  <= io_sync1_q;
                            nib_q <= 1'b1;
                        end else begin
                            nib_q   <= 1'b0;
                            state_q <= (byte_s == OPC_WRITE) ? ST_DATA : ST_ERR;
                        end
                    end
                end
                ST_DATA: begin
                    if (cs_rise) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (sclk_rise) begin
                        if (!nib_q) begin
                            hi_q  <= io_sync1_q;
                            nib_q <= 1'b1;
                        end else begin
                            nib_q     <= 1'b0;
                            payload_q <= byte_s;
`ifdef QSPI_CTRL_CKSUM_EN
                            state_q   <= ST_CKS;
`else
                            state_q   <= ST_WAIT_END;
`endif
                        end
                    end
                end
`ifdef QSPI_CTRL_CKSUM_EN
                ST_CKS: begin
                    if (cs_rise) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (sclk_rise) begin
                        if (!nib_q) begin
                            hi_q  <= io_sync1_q;
                            nib_q <= 1'b1;
                        end else begin
                            nib_q   <= 1'b0;
                            state_q <= (byte_s == ~(OPC_WRITE ^ payload_q)) ? ST_WAIT_END : ST_ERR;
                        end
                    end
                end
`endif
                ST_WAIT_END: begin
                    if (cs_rise) begin
                        control_q     <= payload_q;
                        clk_control_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else if (sclk_rise) begin
                        state_q <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    if (cs_rise) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    nib_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qspi_ctrl_rx.sv
// Self-checking bench for qspi_ctrl_rx: expected strobes are queued per frame and
// matched by a monitor; frame tasks also check strobe timing and control stability.
module tb_qspi_ctrl_rx;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    qspi_ctrl_rx_if bus();

    qspi_ctrl_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic       is_err;
        logic [7:0] ctrl;
    } exp_t;

    exp_t       exp_q[$];
    int         checks     = 0;
    int         errors     = 0;
    int         strobe_cnt = 0;
    logic [7:0] model_ctrl = 8'h00;

`ifdef QSPI_CTRL_CKSUM_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    function automatic logic [7:0] cks(input logic [7:0] a, input logic [7:0] b);
        return ~(a ^ b);
    endfunction

    // Strobe monitor: pops the scoreboard on every strobe.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.clk_control === 1'b1 && bus.frame_err === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL strobe_overlap: clk_control and frame_err both high at %0t", $time);
            end
            if (bus.clk_control === 1'b1 || bus.frame_err === 1'b1) begin
                exp_t e;
                strobe_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected: got cc=%0b fe=%0b, expected no strobe", bus.clk_control, bus.frame_err);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.frame_err !== e.is_err || (!e.is_err && bus.control !== e.ctrl)) begin
                        errors++;
                        $display("FAIL strobe_kind: got fe=%0b control=%02h, expected fe=%0b control=%02h",
                                 bus.frame_err, bus.control, e.is_err, e.ctrl);
                    end
                end
            end
        end
    end

    task automatic send_nibble(input logic [3:0] n);
        @(negedge clk) bus.io = n;
        repeat (4) @(negedge clk);
        bus.sclk = 1'b1;
        repeat (4) @(negedge clk);
        bus.sclk = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int nnib, input bit exp_err, input string name);
        exp_t        e;
        logic [23:0] fr;
        fr       = {b0, b1, b2};
        e.is_err = exp_err;
        e.ctrl   = exp_err ? model_ctrl : b1;
        exp_q.push_back(e);
        strobe_cnt = 0;
        @(negedge clk) bus.cs_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_in_frame: got %0b expected 1", name, bus.busy);
        end
        for (int i = 0; i < nnib; i++) begin
            send_nibble(fr[23 - 4*i -: 4]);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (strobe_cnt !== 0 || bus.control !== model_ctrl) begin
            errors++;
            $display("FAIL %s pre_end: strobes=%0d control=%02h expected 0 strobes control=%02h",
                     name, strobe_cnt, bus.control, model_ctrl);
        end
        @(negedge clk) bus.cs_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.clk_control, bus.frame_err} !== 2'b00) begin
            errors++;
            $display("FAIL %s strobe_early: got %02b expected 00", name, {bus.clk_control, bus.frame_err});
        end
        @(negedge clk);
        checks++;
        if ({bus.clk_control, bus.frame_err} !== (exp_err ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL %s strobe_timing: got %02b expected %02b", name,
                     {bus.clk_control, bus.frame_err}, (exp_err ? 2'b01 : 2'b10));
        end
        repeat (12) @(negedge clk);
        if (!exp_err) begin
            model_ctrl = b1;
        end
        checks++;
        if (strobe_cnt !== 1 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL %s strobe_count: got %0d strobes, %0d pending, expected 1 and 0",
                     name, strobe_cnt, exp_q.size());
        end
        checks++;
        if (bus.control !== model_ctrl || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s post_frame: control=%02h busy=%0b expected control=%02h busy=0",
                     name, bus.control, bus.busy, model_ctrl);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cs_n = 1'b1;
        bus.sclk = 1'b0;
        bus.io   = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.control !== 8'h00 || bus.clk_control !== 1'b0 || bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: control=%02h cc=%0b fe=%0b busy=%0b expected 00 0 0 0",
                     bus.control, bus.clk_control, bus.frame_err, bus.busy);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_valid_frame();
        run_frame(8'h01, 8'hC5, cks(8'h01, 8'hC5), 2*NB, 1'b0, "valid_c5");
    endtask

    task automatic test_bad_opcode();
        run_frame(8'h02, 8'h7F, cks(8'h02, 8'h7F), 2*NB, 1'b1, "bad_opcode");
    endtask

    task automatic test_short_frame();
        run_frame(8'h01, 8'h40, 8'h00, 3, 1'b1, "short_frame");
        run_frame(8'h01, 8'h42, cks(8'h01, 8'h42), 2*NB, 1'b0, "after_short");
    endtask

    task automatic test_checksum();
`ifdef QSPI_CTRL_CKSUM_EN
        run_frame(8'h01, 8'hC5, 8'h00, 6, 1'b1, "bad_cks");
`else
        run_frame(8'h01, 8'hC5, 8'h3B, 6, 1'b1, "extra_byte");
`endif
    endtask

    task automatic test_back_to_back();
        run_frame(8'h01, 8'hA7, cks(8'h01, 8'hA7), 2*NB, 1'b0, "b2b_a7");
        run_frame(8'h01, 8'h3C, cks(8'h01, 8'h3C), 2*NB, 1'b0, "b2b_3c");
    endtask

    task automatic test_reset_midframe();
        strobe_cnt = 0;
        @(negedge clk) bus.cs_n = 1'b0;
        repeat (4) @(negedge clk);
        send_nibble(4'h0);
        send_nibble(4'h1);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.control !== 8'h00 || bus.clk_control !== 1'b0 || bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: control=%02h cc=%0b fe=%0b busy=%0b expected 00 0 0 0",
                     bus.control, bus.clk_control, bus.frame_err, bus.busy);
        end
        rst = 1'b0;
        model_ctrl = 8'h00;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy: got %0b expected 1", bus.busy);
        end
        @(negedge clk) bus.cs_n = 1'b1;
        repeat (15) @(negedge clk);
        checks++;
        if (strobe_cnt !== 0 || bus.control !== 8'h00) begin
            errors++;
            $display("FAIL midframe_no_start: strobes=%0d control=%02h expected 0 and 00", strobe_cnt, bus.control);
        end
        run_frame(8'h01, 8'h81, cks(8'h01, 8'h81), 2*NB, 1'b0, "after_reset_81");
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_opcode();
        test_short_frame();
        test_checksum();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
